// File: rtl/proc_pkg.sv
// Shared processor definitions: word/field widths, opcode map, fetch FSM states
// and helpers that split an instruction word into its opcode and operand fields.
package proc_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;
  localparam int ADDR_W = DATA_W - OP_W;

  localparam logic [OP_W-1:0] OP_ALU0  = 3'd0;
  localparam logic [OP_W-1:0] OP_ALU1  = 3'd1;
  localparam logic [OP_W-1:0] OP_ALU2  = 3'd2;
  localparam logic [OP_W-1:0] OP_ALU3  = 3'd3;
  localparam logic [OP_W-1:0] OP_STORE = 3'd4;
  localparam logic [OP_W-1:0] OP_LOAD  = 3'd5;
  localparam logic [OP_W-1:0] OP_JUMP  = 3'd6;
  localparam logic [OP_W-1:0] OP_HALT  = 3'd7;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    ISSUE     = 2'd1,
    WAIT_CTRL = 2'd2,
    HALTED    = 2'd3
  } fetch_state_e;

  // Opcode lives in the top OP_W bits of the instruction word.
  function automatic logic [OP_W-1:0] instr_op(input logic [DATA_W-1:0] instr);
    return instr[DATA_W-1 -: OP_W];
  endfunction

  // Operand is everything below the opcode.
  function automatic logic [ADDR_W-1:0] instr_operand(input logic [DATA_W-1:0] instr);
    return instr[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: synchronous reset to RESET_PC, load (highest priority),
// increment with natural wrap at 2^ADDR_W, otherwise hold.
module pc_reg
  import proc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  output logic [ADDR_W-1:0] pc_o
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next-PC selection: a jump target beats a sequential step.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_ONE;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reads instruction memory at the PC with a
// request/acknowledge handshake, latches the word into IR, pulses instr_valid
// and then waits for the control unit to step, jump or halt.
module fetch_unit
  import proc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              halt,
  output logic [OP_W-1:0]   op,
  output logic [ADDR_W-1:0] operand,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_e      state_q;
  logic [DATA_W-1:0] ir_q;
  logic              mem_rd_q;
  logic              instr_valid_q;
  logic              halted_q;

  logic              cmd_window;
  logic              cmd_load;
  logic              cmd_inc;
  logic [ADDR_W-1:0] pc_cur;

  // Control commands only act while waiting; halt masks load and inc,
  // which covers the control unit's registered one-cycle latency.
  assign cmd_window = (state_q == WAIT_CTRL);
  assign cmd_load   = cmd_window && !halt && load_pc;
  assign cmd_inc    = cmd_window && !halt && !load_pc && inc_pc;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (cmd_inc),
    .load_i     (cmd_load),
    .load_addr_i(load_addr),
    .pc_o       (pc_cur)
  );

  // Fetch sequencer with registered request, IR, valid pulse and halted flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      ir_q          <= '0;
      mem_rd_q      <= 1'b1;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      case (state_q)
        FETCH: begin
          if (mem_ack) begin
            ir_q          <= mem_rdata;
            mem_rd_q      <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT_CTRL;
        end
        WAIT_CTRL: begin
          if (halt) begin
            halted_q <= 1'b1;
            state_q  <= HALTED;
          end else if (load_pc || inc_pc) begin
            mem_rd_q <= 1'b1;
            state_q  <= FETCH;
          end
        end
        HALTED: begin
          halted_q <= 1'b1;
          mem_rd_q <= 1'b0;
        end
        default: begin
          mem_rd_q <= 1'b0;
          halted_q <= 1'b1;
          state_q  <= HALTED;
        end
      endcase
    end
  end

  // A request may never be visible while reset is asserted, so any
  // in-flight fetch is abandoned in the reset cycle itself.
  assign mem_rd      = mem_rd_q && !reset;
  assign mem_addr    = pc_cur;
  assign pc          = pc_cur;
  assign op          = instr_op(ir_q);
  assign operand     = instr_operand(ir_q);
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed per-cycle vector table followed by random
// instruction transactions checked against a transaction-level model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [12:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        inc_pc;
  logic        load_pc;
  logic [12:0] load_addr;
  logic        halt;
  logic [2:0]  op;
  logic [12:0] operand;
  logic        instr_valid;
  logic [12:0] pc;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit #(.RESET_PC(13'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .inc_pc     (inc_pc),
    .load_pc    (load_pc),
    .load_addr  (load_addr),
    .halt       (halt),
    .op         (op),
    .operand    (operand),
    .instr_valid(instr_valid),
    .pc         (pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        ack;
    logic [15:0] rdata;
    logic        inc;
    logic        ld;
    logic [12:0] laddr;
    logic        hlt;
    logic        e_rd;
    logic [12:0] e_addr;
    logic        e_vld;
    logic [15:0] e_ir;
    logic [12:0] e_pc;
    logic        e_h;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic r, input logic a,
                              input logic [15:0] rd, input logic i, input logic l,
                              input logic [12:0] la, input logic h, input logic erd,
                              input logic [12:0] eaddr, input logic evld,
                              input logic [15:0] eir, input logic [12:0] epc,
                              input logic eh);
    vec_t v;
    v.name = nm; v.rst = r; v.ack = a; v.rdata = rd; v.inc = i; v.ld = l;
    v.laddr = la; v.hlt = h; v.e_rd = erd; v.e_addr = eaddr; v.e_vld = evld;
    v.e_ir = eir; v.e_pc = epc; v.e_h = eh;
    return v;
  endfunction

  // Expected outputs; op and operand are the top 3 and low 13 bits of IR.
  function automatic logic [44:0] pk(input logic rd, input logic [12:0] addr,
                                     input logic v, input logic [15:0] ir,
                                     input logic [12:0] p, input logic h);
    return {rd, addr, v, ir[15:13], ir[12:0], p, h};
  endfunction

  task automatic cyc(input logic r, input logic a, input logic [15:0] rd,
                     input logic i, input logic l, input logic [12:0] la,
                     input logic h);
    @(negedge clk);
    reset = r; mem_ack = a; mem_rdata = rd;
    inc_pc = i; load_pc = l; load_addr = la; halt = h;
    #1;
  endtask

  task automatic chk(input string nm, input logic [44:0] exp);
    logic [44:0] got;
    got = {mem_rd, mem_addr, instr_valid, op, operand, pc, halted};
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got rd=%0b addr=%h vld=%0b op=%0d opnd=%h pc=%h halted=%0b, expected rd=%0b addr=%h vld=%0b op=%0d opnd=%h pc=%h halted=%0b",
               nm, got[44], got[43:31], got[30], got[29:27], got[26:14], got[13:1], got[0],
               exp[44], exp[43:31], exp[30], exp[29:27], exp[26:14], exp[13:1], exp[0]);
    end
  endtask

  vec_t        tbl[$];
  logic [15:0] mem [8192];
  logic [12:0] pc_m;
  logic [15:0] ir_m;
  logic [12:0] la;
  logic        hb, lb, ib, a;
  int          d, w;

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000;
    inc_pc = 1'b0; load_pc = 1'b0; load_addr = 13'h0000; halt = 1'b0;

    //         name             rst   ack   rdata     inc   ld    laddr     hlt  | rd    addr      vld   ir        pc        halted
    tbl.push_back(mk("reset",        1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 1'b0, 16'h0000, 13'h0000, 1'b0));
    tbl.push_back(mk("zw_fetch",     1'b0, 1'b1, 16'h2005, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0000, 1'b0, 16'h0000, 13'h0000, 1'b0));
    tbl.push_back(mk("zw_issue",     1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 1'b1, 16'h2005, 13'h0000, 1'b0));
    tbl.push_back(mk("zw_wait_inc",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 1'b0, 16'h2005, 13'h0000, 1'b0));
    tbl.push_back(mk("ws_fetch0",    1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0001, 1'b0, 16'h2005, 13'h0001, 1'b0));
    tbl.push_back(mk("ws_fetch1",    1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0001, 1'b0, 16'h2005, 13'h0001, 1'b0));
    tbl.push_back(mk("ws_fetch2",    1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 13'h0777, 1'b1, 1'b1, 13'h0001, 1'b0, 16'h2005, 13'h0001, 1'b0));
    tbl.push_back(mk("ws_fetch3",    1'b0, 1'b1, 16'hA123, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0001, 1'b0, 16'h2005, 13'h0001, 1'b0));
    tbl.push_back(mk("ws_issue",     1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 13'h0555, 1'b0, 1'b0, 13'h0001, 1'b1, 16'hA123, 13'h0001, 1'b0));
    tbl.push_back(mk("pri_ld_inc",   1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 13'h0100, 1'b0, 1'b0, 13'h0001, 1'b0, 16'hA123, 13'h0001, 1'b0));
    tbl.push_back(mk("pri_fetch",    1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0100, 1'b0, 16'hA123, 13'h0100, 1'b0));
    tbl.push_back(mk("ld_issue",     1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0100, 1'b1, 16'h3333, 13'h0100, 1'b0));
    tbl.push_back(mk("stray_ack_ld", 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 13'h1FFF, 1'b0, 1'b0, 13'h0100, 1'b0, 16'h3333, 13'h0100, 1'b0));
    tbl.push_back(mk("wrap_fetch",   1'b0, 1'b1, 16'h4444, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h1FFF, 1'b0, 16'h3333, 13'h1FFF, 1'b0));
    tbl.push_back(mk("wrap_issue",   1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h1FFF, 1'b1, 16'h4444, 13'h1FFF, 1'b0));
    tbl.push_back(mk("wrap_inc",     1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h1FFF, 1'b0, 16'h4444, 13'h1FFF, 1'b0));
    tbl.push_back(mk("halt_fetch",   1'b0, 1'b1, 16'hE000, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0000, 1'b0, 16'h4444, 13'h0000, 1'b0));
    tbl.push_back(mk("halt_issue",   1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 13'h0000, 1'b1, 1'b0, 13'h0000, 1'b1, 16'hE000, 13'h0000, 1'b0));
    tbl.push_back(mk("halt_pri",     1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 13'h0AAA, 1'b1, 1'b0, 13'h0000, 1'b0, 16'hE000, 13'h0000, 1'b0));
    for (int k = 0; k < 20; k++) begin
      tbl.push_back(mk("halted_hold", 1'b0, (k % 3) == 0, 16'hFFFF, k[0], k[1], 13'h0123, k[2],
                       1'b0, 13'h0000, 1'b0, 16'hE000, 13'h0000, 1'b1));
    end
    tbl.push_back(mk("halt_reset",   1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 1'b0, 16'hE000, 13'h0000, 1'b1));
    tbl.push_back(mk("post_reset",   1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0000, 1'b0, 16'h0000, 13'h0000, 1'b0));
    tbl.push_back(mk("rm_issue",     1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 1'b1, 16'h1234, 13'h0000, 1'b0));
    tbl.push_back(mk("rm_load",      1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 13'h0042, 1'b0, 1'b0, 13'h0000, 1'b0, 16'h1234, 13'h0000, 1'b0));
    tbl.push_back(mk("rm_fetch",     1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0042, 1'b0, 16'h1234, 13'h0042, 1'b0));
    tbl.push_back(mk("rm_reset_ack", 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0042, 1'b0, 16'h1234, 13'h0042, 1'b0));
    tbl.push_back(mk("rm_refetch",   1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0000, 1'b0, 16'h0000, 13'h0000, 1'b0));
    tbl.push_back(mk("rm_no_valid",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 13'h0000, 1'b0, 16'h0000, 13'h0000, 1'b0));

    // One unchecked reset cycle puts the design into a known state.
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 13'h0000, 1'b0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].ack, tbl[i].rdata, tbl[i].inc, tbl[i].ld, tbl[i].laddr, tbl[i].hlt);
      chk(tbl[i].name, pk(tbl[i].e_rd, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_ir, tbl[i].e_pc, tbl[i].e_h));
    end

    // Random transactions: the design is in FETCH at PC 0 with IR cleared.
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    pc_m = 13'h0000;
    ir_m = 16'h0000;
    for (int n = 0; n < 200; n++) begin
      d = $urandom_range(0, 3);
      for (int k = 0; k <= d; k++) begin
        a = (k == d);
        cyc(1'b0, a, a ? mem[pc_m] : 16'($urandom), 1'($urandom), 1'($urandom), 13'($urandom), 1'($urandom));
        chk("rnd_fetch", pk(1'b1, pc_m, 1'b0, ir_m, pc_m, 1'b0));
      end
      ir_m = mem[pc_m];
      cyc(1'b0, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 13'($urandom), 1'($urandom));
      chk("rnd_issue", pk(1'b0, pc_m, 1'b1, ir_m, pc_m, 1'b0));
      w = $urandom_range(0, 2);
      for (int k = 0; k < w; k++) begin
        cyc(1'b0, 1'($urandom), 16'($urandom), 1'b0, 1'b0, 13'($urandom), 1'b0);
        chk("rnd_idle", pk(1'b0, pc_m, 1'b0, ir_m, pc_m, 1'b0));
      end
      hb = ($urandom_range(0, 24) == 0);
      lb = ($urandom_range(0, 3) == 0);
      ib = 1'($urandom);
      if (!hb && !lb) ib = 1'b1;
      la = ($urandom_range(0, 3) == 0) ? (13'h1FFE | 13'($urandom_range(0, 1))) : 13'($urandom);
      cyc(1'b0, 1'($urandom), 16'($urandom), ib, lb, la, hb);
      chk("rnd_cmd", pk(1'b0, pc_m, 1'b0, ir_m, pc_m, 1'b0));
      if (hb) begin
        for (int k = 0; k < 3; k++) begin
          cyc(1'b0, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 13'($urandom), 1'($urandom));
          chk("rnd_halted", pk(1'b0, pc_m, 1'b0, ir_m, pc_m, 1'b1));
        end
        cyc(1'b1, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 13'($urandom), 1'($urandom));
        chk("rnd_reset", pk(1'b0, pc_m, 1'b0, ir_m, pc_m, 1'b1));
        pc_m = 13'h0000;
        ir_m = 16'h0000;
      end else if (lb) begin
        pc_m = la;
      end else begin
        pc_m = pc_m + 13'd1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
